full_adder_checker: RTL

- Synthesizable response checker for the clocked 1-bit full adder; sits on the DUT output side, opposite the stimulus driver.
- Each cycle it taps the operands driven into the adder and computes the expected {cout,sum}.
- It delays that expected value by the adder's pipeline latency and compares it against the DUT's registered outputs.
- Reports per-vector mismatch, saturating error/vector counts, first-failure capture, input-combination coverage and an overall pass flag.

---
 rtl/full_adder_checker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/full_adder_checker.sv
`default_nettype none
// ============================================================================
//  Module      : full_adder_checker
//  Description : Response checker for a clocked 1-bit full adder. Taps the
//                operands, computes the expected {cout,sum}, delays it by the
//                adder's pipeline latency and compares it against the DUT's
//                outputs. Reports mismatch pulses, saturating counters,
//                first-failure capture, input coverage and a pass flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module full_adder_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             sum,
  input  logic             cout,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [1:0]       first_err_exp,
  output logic [1:0]       first_err_got,
  output logic [7:0]       coverage,
  output logic             pass
);

  // Latency outside 1..8 is rejected at elaboration.
  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("full_adder_checker: LATENCY must be in 1..8");
  end

  localparam int               c_LAST    = LATENCY - 1;
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CHECK = 2'd2,
    S_FAIL  = 2'd3
  } t_state;

  // Delay line: one slot per pipeline stage of the adder under test.
  logic       r_dl_vld [LATENCY];
  logic [1:0] r_dl_exp [LATENCY];
  logic [2:0] r_dl_idx [LATENCY];

  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_vec_count;
  logic             r_first_valid;
  logic [CNT_W-1:0] r_first_idx;
  logic [1:0]       r_first_exp;
  logic [1:0]       r_first_got;
  logic [7:0]       r_coverage;
  t_state           r_state;

  logic [1:0] w_exp;
  logic [1:0] w_got;
  logic       w_chk_vld;
  logic [1:0] w_chk_exp;
  logic [2:0] w_chk_idx;
  logic       w_mismatch;

  assign w_exp     = {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  assign w_got     = {cout, sum};
  assign w_chk_vld = r_dl_vld[c_LAST];
  assign w_chk_exp = r_dl_exp[c_LAST];
  assign w_chk_idx = r_dl_idx[c_LAST];
  // Case inequality so that X/Z on the DUT outputs is flagged in simulation.
  assign w_mismatch = w_chk_vld & (w_got !== w_chk_exp);

  // Shift the sampled operands and expected result down the delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_dl_vld[i] <= 1'b0;
        r_dl_exp[i] <= 2'b00;
        r_dl_idx[i] <= 3'b000;
      end
    end else begin
      r_dl_vld[0] <= en;
      r_dl_exp[0] <= w_exp;
      r_dl_idx[0] <= {a, b, cin};
      for (int i = 1; i < LATENCY; i++) begin
        r_dl_vld[i] <= r_dl_vld[i-1];
        r_dl_exp[i] <= r_dl_exp[i-1];
        r_dl_idx[i] <= r_dl_idx[i-1];
      end
    end
  end

  // Score checked vectors, capture the first failure and track the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_pulse   <= 1'b0;
      r_err_count   <= '0;
      r_vec_count   <= '0;
      r_first_valid <= 1'b0;
      r_first_idx   <= '0;
      r_first_exp   <= 2'b00;
      r_first_got   <= 2'b00;
      r_coverage    <= 8'h00;
      r_state       <= S_IDLE;
    end else begin
      r_err_pulse <= w_mismatch;

      if (w_chk_vld) begin
        if (r_vec_count != c_CNT_MAX) begin
          r_vec_count <= r_vec_count + 1'b1;
        end
        r_coverage[w_chk_idx] <= 1'b1;
      end

      if (w_mismatch) begin
        if (r_err_count != c_CNT_MAX) begin
          r_err_count <= r_err_count + 1'b1;
        end
        // Index is the count before this vector is added, i.e. 0-based.
        if (!r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_idx   <= r_vec_count;
          r_first_exp   <= w_chk_exp;
          r_first_got   <= w_got;
        end
      end

      case (r_state)
        S_IDLE:  if (en) r_state <= S_FILL;
        S_FILL:  if (w_chk_vld) r_state <= w_mismatch ? S_FAIL : S_CHECK;
        S_CHECK: if (w_mismatch) r_state <= S_FAIL;
        S_FAIL:  r_state <= S_FAIL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign err_pulse       = r_err_pulse;
  assign err_count       = r_err_count;
  assign vec_count       = r_vec_count;
  assign first_err_valid = r_first_valid;
  assign first_err_idx   = r_first_idx;
  assign first_err_exp   = r_first_exp;
  assign first_err_got   = r_first_got;
  assign coverage        = r_coverage;
  // Errors never decrement, so pass stays low once any error is counted.
  assign pass            = (r_coverage == 8'hFF) && (r_err_count == '0);

endmodule
`default_nettype wire
